// File: rtl/onehot_chk_pkg.sv
// Shared types and helpers for the one-hot stream checker.
// Holds the check-mode enum and the popcount-width helper.
package onehot_chk_pkg;

  typedef enum logic [1:0] {
    ONEHOT         = 2'd0,
    ZERO_OR_ONEHOT = 2'd1,
    ONECOLD        = 2'd2,
    EXACT_K        = 2'd3
  } chk_mode_e;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/onehot_stream_checker_popcount.sv
// Combinational popcount and lowest-set-bit finder.
// Ports: din -> count (set bits), idx (lowest set bit, 0 if none).
module popcount_lsb
  import onehot_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = cnt_width(DATA_WIDTH),
  parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CNT_W-1:0]      count,
  output logic [IDX_W-1:0]      idx
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      count = count + CNT_W'(din[i]);
  end

  // Scan from the top down so the last hit is the lowest bit.
  always_comb begin
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      if (din[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/onehot_stream_checker.sv
// Two-stage streaming popcount-mode checker with saturating stats.
// Ports: in_* / din / mode / k_target in, out_* result, stats out.
module onehot_stream_checker
  import onehot_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAT_W     = 16,
  parameter int CNT_W      = cnt_width(DATA_WIDTH),
  parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      k_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_pass,
  output logic [CNT_W-1:0]      out_count,
  output logic [IDX_W-1:0]      out_index,
  input  logic                  clear_stats,
  output logic [STAT_W-1:0]     hit_cnt,
  output logic [STAT_W-1:0]     miss_cnt,
  output logic                  sticky_err
);

  logic [CNT_W-1:0] pc_count;
  logic [IDX_W-1:0] pc_idx;

  popcount_lsb #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_pc (
    .din   (din),
    .count (pc_count),
    .idx   (pc_idx)
  );

  logic             s1_valid;
  logic [CNT_W-1:0] s1_count;
  logic [IDX_W-1:0] s1_idx;
  chk_mode_e        s1_mode;
  logic [CNT_W-1:0] s1_k;
  logic             s2_valid;

  logic advance1, advance2, accept, deliver;
  logic verdict;

  assign advance2 = ~s2_valid | out_ready;
  assign advance1 = ~s1_valid | advance2;
  assign in_ready = advance1;
  assign accept   = in_valid & advance1;
  assign deliver  = s2_valid & out_ready;
  assign out_valid = s2_valid;

  // An oversized k_target can never equal a real popcount,
  // so EXACT_K needs no separate range check.
  always_comb begin
    verdict = 1'b0;
    unique case (s1_mode)
      ONEHOT:         verdict = (s1_count == CNT_W'(1));
      ZERO_OR_ONEHOT: verdict = (s1_count <= CNT_W'(1));
      ONECOLD:        verdict = (s1_count == CNT_W'(DATA_WIDTH - 1));
      EXACT_K:        verdict = (s1_count == s1_k);
      default:        verdict = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s1_idx   <= '0;
      s1_mode  <= ONEHOT;
      s1_k     <= '0;
    end else if (advance1) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_count <= pc_count;
        s1_idx   <= pc_idx;
        s1_mode  <= chk_mode_e'(mode);
        s1_k     <= k_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      out_pass  <= 1'b0;
      out_count <= '0;
      out_index <= '0;
    end else if (advance2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_pass  <= verdict;
        out_count <= s1_count;
        out_index <= s1_idx;
      end
    end
  end

  // Clear takes priority over a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      sticky_err <= 1'b0;
    end else if (deliver) begin
      if (out_pass) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + STAT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + STAT_W'(1);
        sticky_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_onehot_stream_checker.sv
// Directed self-checking bench for onehot_stream_checker.
// Linear stimulus sequence with immediate assertions.
module tb_onehot_stream_checker;
  import onehot_chk_pkg::*;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int CW = 6;
  localparam int IW = 5;

  logic          clk = 0;
  logic          reset = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [DW-1:0] din = '0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] k_target = '0;
  logic          out_valid;
  logic          out_ready = 1;
  logic          out_pass;
  logic [CW-1:0] out_count;
  logic [IW-1:0] out_index;
  logic          clear_stats = 0;
  logic [SW-1:0] hit_cnt;
  logic [SW-1:0] miss_cnt;
  logic          sticky_err;

  int tests = 0;
  int fails = 0;

  onehot_stream_checker #(
    .DATA_WIDTH (DW),
    .STAT_W     (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din         (din),
    .mode        (mode),
    .k_target    (k_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pass    (out_pass),
    .out_count   (out_count),
    .out_index   (out_index),
    .clear_stats (clear_stats),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .sticky_err  (sticky_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d,
                      input logic [1:0] m,
                      input logic [CW-1:0] k);
    in_valid = 1;
    din      = d;
    mode     = m;
    k_target = k;
    step();
    in_valid = 0;
  endtask

  task automatic res(input string tag,
                     input logic p,
                     input logic [CW-1:0] c,
                     input logic [IW-1:0] x);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_pass"},  64'(out_pass),  64'(p));
    chk({tag, "_count"}, 64'(out_count), 64'(c));
    chk({tag, "_index"}, 64'(out_index), 64'(x));
  endtask

  initial begin
    int sent, got, t;
    logic [IW-1:0] held_idx;
    logic          was_stall;

    step();
    step();
    reset = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_in_ready",  64'(in_ready),  64'(1'b1));
    chk("rst_pass",      64'(out_pass),  64'(1'b0));
    chk("rst_count",     64'(out_count), 64'(0));
    chk("rst_index",     64'(out_index), 64'(0));
    chk("rst_hit",       64'(hit_cnt),   64'(0));
    chk("rst_miss",      64'(miss_cnt),  64'(0));
    chk("rst_sticky",    64'(sticky_err), 64'(1'b0));

    // Basic latency: accept at N, result at N+2.
    push(32'h0000_0400, 2'd0, '0);
    chk("lat_n1_valid", 64'(out_valid), 64'(1'b0));
    step();
    res("onehot_bit10", 1'b1, 6'd1, 5'd10);
    chk("hit_before_deliver", 64'(hit_cnt), 64'(0));
    step();
    chk("hit_after_deliver", 64'(hit_cnt), 64'(1));
    chk("idle_valid", 64'(out_valid), 64'(1'b0));

    // Zero word under ONEHOT vs ZERO_OR_ONEHOT.
    clear_stats = 1;
    step();
    clear_stats = 0;
    push(32'h0, 2'd0, '0);
    push(32'h0, 2'd1, '0);
    res("zero_onehot", 1'b0, 6'd0, 5'd0);
    step();
    res("zero_zoh", 1'b1, 6'd0, 5'd0);
    step();
    chk("zero_hit",    64'(hit_cnt),    64'(1));
    chk("zero_miss",   64'(miss_cnt),   64'(1));
    chk("zero_sticky", 64'(sticky_err), 64'(1'b1));

    // Onecold, full word, exact-k back to back.
    push(32'hFFFF_FFFE, 2'd2, '0);
    push(32'hFFFF_FFFF, 2'd0, '0);
    res("onecold", 1'b1, 6'd31, 5'd1);
    push(32'h8000_0003, 2'd3, 6'd3);
    res("full_word", 1'b0, 6'd32, 5'd0);
    step();
    res("exact_k3", 1'b1, 6'd3, 5'd0);
    step();
    push(32'h8000_0003, 2'd3, 6'd33);
    step();
    res("exact_k_over", 1'b0, 6'd3, 5'd0);
    step();

    // Eight words with a four-cycle output stall.
    sent = 0;
    got = 0;
    was_stall = 0;
    held_idx = '0;
    t = 0;
    while (got < 8 && t < 40) begin
      out_ready = !(t >= 3 && t <= 6);
      in_valid  = (sent < 8);
      din       = DW'(1) << (sent + 3);
      mode      = 2'd0;
      #1;
      if (t == 4)
        chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
      if (was_stall)
        chk("stall_hold_idx", 64'(out_index), 64'(held_idx));
      was_stall = out_valid & ~out_ready;
      held_idx  = out_index;
      if (out_valid && out_ready) begin
        chk("stream_idx",  64'(out_index), 64'(got + 3));
        chk("stream_pass", 64'(out_pass),  64'(1'b1));
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
      t++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("stream_delivered", 64'(got), 64'(8));
    step();
    step();
    chk("stream_no_extra", 64'(out_valid), 64'(1'b0));

    // Saturation of the miss counter.
    clear_stats = 1;
    step();
    clear_stats = 0;
    in_valid = 1;
    din  = '0;
    mode = 2'd0;
    for (int i = 0; i < 65534; i++) step();
    in_valid = 0;
    step();
    step();
    step();
    chk("miss_fffe", 64'(miss_cnt), 64'(16'hFFFE));
    push(32'h0, 2'd0, '0);
    push(32'h0, 2'd0, '0);
    push(32'h0, 2'd0, '0);
    step();
    step();
    step();
    chk("miss_sat", 64'(miss_cnt), 64'(16'hFFFF));

    // Clear on the same cycle as a delivered pass.
    push(32'h1, 2'd0, '0);
    step();
    chk("clr_pass_valid", 64'(out_valid & out_pass), 64'(1'b1));
    clear_stats = 1;
    step();
    clear_stats = 0;
    chk("clr_hit",    64'(hit_cnt),    64'(0));
    chk("clr_miss",   64'(miss_cnt),   64'(0));
    chk("clr_sticky", 64'(sticky_err), 64'(1'b0));

    // Reset with two words in flight.
    push(32'h0, 2'd0, '0);
    step();
    step();
    chk("pre_rst_miss", 64'(miss_cnt), 64'(1));
    out_ready = 0;
    push(32'h2, 2'd0, '0);
    push(32'h4, 2'd0, '0);
    chk("pre_rst_valid", 64'(out_valid), 64'(1'b1));
    reset = 1;
    step();
    reset = 0;
    out_ready = 1;
    #1;
    chk("mid_rst_valid",  64'(out_valid),  64'(1'b0));
    chk("mid_rst_hit",    64'(hit_cnt),    64'(0));
    chk("mid_rst_miss",   64'(miss_cnt),   64'(0));
    chk("mid_rst_sticky", 64'(sticky_err), 64'(1'b0));
    chk("mid_rst_ready",  64'(in_ready),   64'(1'b1));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_late_out", 64'(out_valid), 64'(1'b0));
    end
    chk("post_rst_hit", 64'(hit_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onehot_stream_checker.md
Name: onehot_stream_checker

Overview:
- Streaming, pipelined successor to the combinational one-hot detector.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake and classifies each word by population count under a per-word mode.
- Returns the verdict, the popcount and the lowest-set-bit index two cycles after acceptance.
- Keeps saturating hit/miss statistics and a sticky error flag. Sits between a bus-capture stage and the checker/monitor fabric.

Parameters:
- DATA_WIDTH, 32, input word width (>=2).
- STAT_W, 16, width of hit/miss statistic counters.
- CNT_W, $clog2(DATA_WIDTH+1), popcount width. Derived; must hold the value DATA_WIDTH (32 needs 6 bits, not 5).
- IDX_W, $clog2(DATA_WIDTH), bit-index width. Derived.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  word available.
- in_ready  out  1  block can accept a word.
- din  in  DATA_WIDTH  data word.
- mode  in  2  check mode, sampled with din: 0 ONEHOT, 1 ZERO_OR_ONEHOT, 2 ONECOLD, 3 EXACT_K.
- k_target  in  CNT_W  required popcount for EXACT_K, sampled with din.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_pass  out  1  word satisfied its mode.
- out_count  out  CNT_W  popcount of the word.
- out_index  out  IDX_W  lowest set bit position; 0 when din==0.
- clear_stats  in  1  synchronous clear of stats and sticky flag.
- hit_cnt  out  STAT_W  accepted-result passes, saturating.
- miss_cnt  out  STAT_W  accepted-result fails, saturating.
- sticky_err  out  1  set by any delivered fail.

Behaviour:
- Clocking: one clock (clk); synchronous active-high reset. On reset all outputs are 0:
  - both stage-valid flags, out_valid, out_pass, out_count, out_index;
  - hit_cnt, miss_cnt, sticky_err.
  - in_ready follows from the valid flags, so it is 1 from the first cycle after reset.
- Pipeline has two register stages:
  - S1 registers the popcount, index, mode and k_target.
  - S2 registers the verdict and presents the out_* fields.
- Handshake:
  - advance2 = ~s2_valid | out_ready.
  - advance1 = ~s1_valid | advance2.
  - in_ready = advance1. in_ready is combinational from out_ready; no combinational path from in_valid to in_ready.
  - Accept when in_valid & in_ready.
- Latency and throughput: a word accepted in cycle N gives out_valid in cycle N+2 if out_ready stays high. One word per cycle under continuous flow.
- Stall: while out_valid & ~out_ready, the S2 fields hold stable. S1 fills, then in_ready drops. No data is lost or duplicated.
- Verdict, from c = popcount:
  - ONEHOT: c==1.
  - ZERO_OR_ONEHOT: c<=1.
  - ONECOLD: c==DATA_WIDTH-1.
  - EXACT_K: c==k_target. A k_target greater than DATA_WIDTH never passes.
- Popcount is a full-width sum. Index is the lowest set bit, priority from bit 0.
- Statistics update only on result delivery (out_valid & out_ready):
  - the pass count increments on pass, the miss count on fail;
  - each saturates at all-ones.
- sticky_err is set on a delivered fail.
- clear_stats: in the same cycle as a delivery, clear wins and the counters become 0, not 1. sticky_err also clears. Pipeline contents are unaffected.
- Reset mid-stream: in-flight words are discarded and no stats update. The first accept is possible the cycle after reset deasserts.

Decomposition:
- Package onehot_chk_pkg holds:
  - typedef enum logic [1:0] chk_mode_e {ONEHOT, ZERO_OR_ONEHOT, ONECOLD, EXACT_K};
  - a function that computes CNT_W from a width.
- Sub-module popcount_lsb (combinational, param DATA_WIDTH): din to count[CNT_W] and idx[IDX_W]. The top instantiates it in front of S1.

Test Plan:
- DATA_WIDTH=32, mode ONEHOT, din=0x0000_0400, out_ready=1 -> out_valid in cycle N+2 with pass=1, count=1, index=10, hit_cnt=1.
- Mode ONEHOT, then ZERO_OR_ONEHOT, both with din=0 -> first pass=0 count=0, second pass=1. Final hit=1, miss=1, sticky_err=1.
- Modes ONECOLD din=0xFFFF_FFFE (pass, count=31, index=1); ONEHOT din=0xFFFF_FFFF (fail, count=32); EXACT_K k=3 din=0x8000_0003 (pass, index=0).
- Back-to-back 8 words with out_ready low for cycles 3-6 -> in_ready low by cycle 4; all 8 results delivered in order, none dropped or duplicated, stable while stalled.
- Force miss_cnt to 0xFFFE, then deliver 3 fails -> saturates at 0xFFFF. clear_stats on the same cycle as a delivered pass -> hit_cnt=0, miss_cnt=0, sticky_err=0.
- Assert reset while 2 words are in flight -> next cycle out_valid=0, counters 0, in_ready=1, and no late outputs appear.
